// File: rtl/sun_pll_ctrl_pkg.sv
// Shared types and constants for the SUN_PLL power-up sequencer / lock detector.
package sun_pll_ctrl_pkg;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned CMP_W = CNT_W + 1;

  localparam int unsigned WINDOW_DEF  = 64;
  localparam int unsigned TOL_DEF     = 2;
  localparam int unsigned GOOD_N_DEF  = 4;
  localparam int unsigned SETTLE_DEF  = 32;
  localparam int unsigned TIMEOUT_DEF = 64;
  localparam int unsigned LOSS_N_DEF  = 2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_SETTLE,
    ST_ACQ,
    ST_LOCK,
    ST_FAULT
  } state_e;

  // Bits needed to hold values 0..n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

  // Increment that sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && (v != CNT_MAX)) ? v + 1'b1 : v;
  endfunction

endpackage

// File: rtl/sun_pll_ctrl_sync.sv
// Three-flop synchronizer for the divided PLL feedback clock with rising-edge detect.
module sun_pll_ctrl_sync
  import sun_pll_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic ck_fb,
  output logic fb_rise
);

  logic s1, s2, s3;

  // Resample CK_FB into the reference domain; s3 is the delayed copy for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= ck_fb;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign fb_rise = s2 & ~s3;

endmodule

// File: rtl/sun_pll_ctrl.sv
// SUN_PLL power-up sequencer and frequency lock detector (CK_REF domain).
// Optional build macro SUN_PLL_CTRL_LOSS_EN: LOSS_N consecutive bad windows in
// LOCK return the FSM to ACQ; without it LOCK is held until EN drops.
module sun_pll_ctrl
  import sun_pll_ctrl_pkg::*;
#(
  parameter int unsigned WINDOW  = WINDOW_DEF,
  parameter int unsigned TOL     = TOL_DEF,
  parameter int unsigned GOOD_N  = GOOD_N_DEF,
  parameter int unsigned SETTLE  = SETTLE_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned LOSS_N  = LOSS_N_DEF
) (
  input  logic             CK_REF,
  input  logic             RN,
  input  logic             EN,
  input  logic             CK_FB,
  output logic             PWRUP_1V8,
  output logic             LOCKED,
  output logic             FAULT,
  output logic [CNT_W-1:0] FB_CNT
);

  localparam int unsigned SET_W = cnt_width(SETTLE);
  localparam int unsigned TOT_W = cnt_width(TIMEOUT);
  // One run counter serves both good-run (ACQ) and bad-run (LOCK) counting.
  localparam int unsigned RUN_W = cnt_width((GOOD_N > LOSS_N) ? GOOD_N : LOSS_N);

  state_e             state, state_nxt;
  logic               fb_rise;
  logic [SET_W-1:0]   settle_cnt;
  logic [CNT_W-1:0]   win_cnt, edge_cnt, total;
  logic [TOT_W-1:0]   win_tot, tot_inc;
  logic [RUN_W-1:0]   run_cnt, run_inc;
  logic               active, window_done, good, settle_last, keep_run;

  sun_pll_ctrl_sync u_sync (
    .clk     (CK_REF),
    .rst_n   (RN),
    .ck_fb   (CK_FB),
    .fb_rise (fb_rise)
  );

  assign active      = (state == ST_ACQ) || (state == ST_LOCK);
  assign keep_run    = (state_nxt == ST_ACQ) || (state_nxt == ST_LOCK);
  assign window_done = active && (win_cnt == CNT_W'(WINDOW - 1));
  assign total       = sat_inc(edge_cnt, fb_rise);
  assign good        = (total != CNT_MAX) &&
                       ({1'b0, total} >= CMP_W'(WINDOW - TOL)) &&
                       ({1'b0, total} <= CMP_W'(WINDOW + TOL));
  assign settle_last = (settle_cnt == SET_W'(SETTLE - 1));
  assign tot_inc     = win_tot + 1'b1;
  assign run_inc     = run_cnt + 1'b1;

  // Next-state selection; EN low overrides every other transition.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_OFF:    if (EN) state_nxt = ST_SETTLE;
      ST_SETTLE: if (settle_last) state_nxt = ST_ACQ;
      ST_ACQ: begin
        if (window_done) begin
          if (good && (run_inc == RUN_W'(GOOD_N))) state_nxt = ST_LOCK;
          else if (tot_inc == TOT_W'(TIMEOUT))     state_nxt = ST_FAULT;
        end
      end
      ST_LOCK: begin
`ifdef SUN_PLL_CTRL_LOSS_EN
        if (window_done && !good && (run_inc == RUN_W'(LOSS_N))) state_nxt = ST_ACQ;
`endif
      end
      ST_FAULT:  state_nxt = ST_FAULT;
      default:   state_nxt = ST_OFF;
    endcase
    if (!EN) state_nxt = ST_OFF;
  end

  // State register with outputs decoded from the next state so they are flop outputs.
  always_ff @(posedge CK_REF or negedge RN) begin
    if (!RN) begin
      state     <= ST_OFF;
      PWRUP_1V8 <= 1'b0;
      LOCKED    <= 1'b0;
      FAULT     <= 1'b0;
    end else begin
      state     <= state_nxt;
      PWRUP_1V8 <= (state_nxt == ST_SETTLE) || (state_nxt == ST_ACQ) || (state_nxt == ST_LOCK);
      LOCKED    <= (state_nxt == ST_LOCK);
      FAULT     <= (state_nxt == ST_FAULT);
    end
  end

  // Settle timer: counts only while remaining in SETTLE.
  always_ff @(posedge CK_REF or negedge RN) begin
    if (!RN)                                              settle_cnt <= '0;
    else if ((state == ST_SETTLE) && (state_nxt == ST_SETTLE)) settle_cnt <= settle_cnt + 1'b1;
    else                                                  settle_cnt <= '0;
  end

  // Window engine: free-running in ACQ/LOCK, cleared otherwise so ACQ entry from SETTLE restarts it.
  always_ff @(posedge CK_REF or negedge RN) begin
    if (!RN) begin
      win_cnt  <= '0;
      edge_cnt <= '0;
      FB_CNT   <= '0;
    end else begin
      if (active && keep_run) begin
        win_cnt  <= window_done ? '0 : win_cnt + 1'b1;
        edge_cnt <= window_done ? '0 : total;
      end else begin
        win_cnt  <= '0;
        edge_cnt <= '0;
      end
      if (window_done) FB_CNT <= total;
    end
  end

  // Window tally and consecutive-run counter; any exit from ACQ/LOCK or ACQ<->LOCK move clears them.
  always_ff @(posedge CK_REF or negedge RN) begin
    if (!RN) begin
      win_tot <= '0;
      run_cnt <= '0;
    end else begin
      if ((state == ST_ACQ) && (state_nxt == ST_ACQ)) begin
        if (window_done) win_tot <= tot_inc;
      end else begin
        win_tot <= '0;
      end

      if ((state == ST_ACQ) && (state_nxt == ST_ACQ)) begin
        if (window_done) run_cnt <= good ? run_inc : '0;
      end
`ifdef SUN_PLL_CTRL_LOSS_EN
      else if ((state == ST_LOCK) && (state_nxt == ST_LOCK)) begin
        if (window_done) run_cnt <= good ? '0 : run_inc;
      end
`endif
      else begin
        run_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sun_pll_ctrl.sv
// Directed bench for sun_pll_ctrl. CK_FB is generated as a per-window pulse count
// aligned to the measurement windows (pulse placement leaves margin for sync latency).
module tb_sun_pll_ctrl;

  localparam int W  = 32;
  localparam int T  = 18;   // good window: 14..50 edges
  localparam int G  = 4;
  localparam int S  = 8;
  localparam int TO = 8;
  localparam int L  = 2;

  logic       CK_REF = 1'b0;
  logic       RN     = 1'b0;
  logic       EN     = 1'b0;
  logic       CK_FB  = 1'b0;
  logic       PWRUP_1V8, LOCKED, FAULT;
  logic [7:0] FB_CNT;

  int n_vec  = 0;
  int n_err  = 0;
  int cyc    = 0;
  int origin = 0;
  bit gen_on = 1'b0;
  int kpat[16];
  int kdef   = 0;

  sun_pll_ctrl #(
    .WINDOW  (W),
    .TOL     (T),
    .GOOD_N  (G),
    .SETTLE  (S),
    .TIMEOUT (TO),
    .LOSS_N  (L)
  ) dut (
    .CK_REF    (CK_REF),
    .RN        (RN),
    .EN        (EN),
    .CK_FB     (CK_FB),
    .PWRUP_1V8 (PWRUP_1V8),
    .LOCKED    (LOCKED),
    .FAULT     (FAULT),
    .FB_CNT    (FB_CNT)
  );

  always #5 CK_REF = ~CK_REF;

  // Window j (from posedge P0 where EN is first seen) gets kpat[j] one-cycle pulses.
  // A pulse driven after posedge m is counted at posedge m+3, so frame j starts at m = S-2+j*W.
  always @(negedge CK_REF) begin : fb_gen
    int rel, j, o, k;
    rel = cyc - origin - (S - 2);
    if (gen_on && rel >= 0) begin
      j = rel / W;
      o = rel % W;
      k = (j < 16) ? kpat[j] : kdef;
      CK_FB = ((o % 2) == 1) && (o < 2 * k);
    end else begin
      CK_FB = 1'b0;
    end
  end

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic expect_outs(input string tag, input logic pw, input logic lk, input logic ft);
    expect_eq({tag, "_pwrup"},  {31'd0, PWRUP_1V8}, {31'd0, pw});
    expect_eq({tag, "_locked"}, {31'd0, LOCKED},    {31'd0, lk});
    expect_eq({tag, "_fault"},  {31'd0, FAULT},     {31'd0, ft});
  endtask

  task automatic tick();
    @(posedge CK_REF);
    cyc++;
    #1;
  endtask

  task automatic run_to(input int n);
    while (cyc < origin + n) tick();
  endtask

  // Raise EN; the next posedge is P0, where PWRUP_1V8 must appear.
  task automatic start_en(input string tag);
    expect_eq({tag, "_pre_pwrup"}, {31'd0, PWRUP_1V8}, 32'd0);
    EN     = 1'b1;
    origin = cyc + 1;
    gen_on = 1'b1;
    tick();
    expect_eq({tag, "_p0_pwrup"}, {31'd0, PWRUP_1V8}, 32'd1);
  endtask

  task automatic fill(input int k);
    for (int i = 0; i < 16; i++) kpat[i] = k;
    kdef = k;
  endtask

  initial begin
    fill(0);
    #2;
    expect_outs("reset", 1'b0, 1'b0, 1'b0);
    expect_eq("reset_fbcnt", {24'd0, FB_CNT}, 32'd0);
    tick();
    RN = 1'b1;
    repeat (4) tick();
    expect_outs("idle", 1'b0, 1'b0, 1'b0);

    // Nominal lock at the lower tolerance edge (14 edges), then feedback lost for two windows.
    fill(14);
    kpat[4] = 0;
    kpat[5] = 0;
    start_en("nom");
    run_to(S + W - 1);
    expect_eq("nom_fbcnt0", {24'd0, FB_CNT}, 32'd0);
    run_to(S + W);
    expect_eq("nom_fbcnt1", {24'd0, FB_CNT}, 32'd14);
    run_to(S + 4 * W - 1);
    expect_outs("nom_prelock", 1'b1, 1'b0, 1'b0);
    run_to(S + 4 * W);
    expect_outs("nom_lock", 1'b1, 1'b1, 1'b0);
    expect_eq("nom_fbcnt4", {24'd0, FB_CNT}, 32'd14);
    run_to(S + 5 * W);
    expect_eq("loss_fbcnt", {24'd0, FB_CNT}, 32'd0);
    expect_eq("loss_w1_locked", {31'd0, LOCKED}, 32'd1);
    run_to(S + 6 * W - 1);
    expect_eq("loss_w2pre_locked", {31'd0, LOCKED}, 32'd1);
    run_to(S + 6 * W);
`ifdef SUN_PLL_CTRL_LOSS_EN
    expect_outs("loss_drop", 1'b1, 1'b0, 1'b0);
    run_to(S + 10 * W - 1);
    expect_outs("relock_pre", 1'b1, 1'b0, 1'b0);
    run_to(S + 10 * W);
    expect_outs("relock", 1'b1, 1'b1, 1'b0);
`else
    expect_outs("loss_hold", 1'b1, 1'b1, 1'b0);
    run_to(S + 10 * W);
    expect_outs("loss_hold_late", 1'b1, 1'b1, 1'b0);
`endif

    // Asynchronous reset mid-cycle while locked and CK_FB toggling.
    run_to(S + 10 * W + 10);
    #2;
    RN = 1'b0;
    #1;
    expect_outs("async_rst", 1'b0, 1'b0, 1'b0);
    expect_eq("async_rst_fbcnt", {24'd0, FB_CNT}, 32'd0);
    EN     = 1'b0;
    gen_on = 1'b0;
    tick();
    RN = 1'b1;
    repeat (4) tick();
    expect_outs("post_rst", 1'b0, 1'b0, 1'b0);

    // 13 edges per window: just below tolerance, must time out.
    fill(13);
    start_en("bad");
    run_to(S + W);
    expect_eq("bad_fbcnt", {24'd0, FB_CNT}, 32'd13);
    run_to(S + 8 * W - 1);
    expect_outs("bad_pretimeout", 1'b1, 1'b0, 1'b0);
    run_to(S + 8 * W);
    expect_outs("bad_timeout", 1'b0, 1'b0, 1'b1);
    run_to(S + 8 * W + 5);
    expect_outs("fault_hold", 1'b0, 1'b0, 1'b1);
    EN = 1'b0;
    tick();
    expect_outs("fault_off", 1'b0, 1'b0, 1'b0);
    repeat (2) tick();

    // good x3, bad, good x4: lock on window 8, coinciding with timeout (lock wins).
    fill(14);
    kpat[3] = 0;
    start_en("mix");
    run_to(S + 4 * W);
    expect_eq("mix_bad_fbcnt", {24'd0, FB_CNT}, 32'd0);
    expect_outs("mix_w4", 1'b1, 1'b0, 1'b0);
    run_to(S + 8 * W - 1);
    expect_outs("mix_prelock", 1'b1, 1'b0, 1'b0);
    run_to(S + 8 * W);
    expect_outs("mix_lock", 1'b1, 1'b1, 1'b0);
    EN = 1'b0;
    tick();
    expect_outs("mix_off", 1'b0, 1'b0, 1'b0);
    repeat (2) tick();

    // EN drop mid-ACQ, then immediate re-enable must repeat the whole settle + 4 windows.
    fill(14);
    start_en("acq");
    run_to(S + W + 5);
    expect_outs("acq_mid", 1'b1, 1'b0, 1'b0);
    EN = 1'b0;
    tick();
    expect_outs("acq_off", 1'b0, 1'b0, 1'b0);
    start_en("restart");
    run_to(S + 4 * W - 1);
    expect_outs("restart_prelock", 1'b1, 1'b0, 1'b0);
    run_to(S + 4 * W);
    expect_outs("restart_lock", 1'b1, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
